// File: rtl/xadac_vd_wb.sv
// xadac_vd_wb: vector writeback stage.
//
// Purpose:
//   Sits directly behind the xadac vector execute slaves. Responses
//   {id, vd_addr, vd_data} are buffered in an in-order FIFO and drained one
//   per cycle into the vector register file write port. A per-register
//   pending-write scoreboard lets decode stall on RAW/WAW hazards, and a
//   registered retire pulse is emitted for every entry written.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           drop every buffered entry (synchronous)
//   in_valid/ready  execute response handshake
//   in_id, in_vd_addr, in_vd_data   response payload
//   wr_en/wr_ready  VRF write handshake (wr_en means the FIFO head is valid)
//   wr_addr/wr_data FIFO head destination register and data
//   done_valid/id   one-cycle retire pulse, registered, one per dequeue
//   vreg_busy       bit r set while any write to register r is buffered
module xadac_vd_wb #(
  parameter int DEPTH      = 4,
  parameter int VEC_DATA_W = 256,
  parameter int ID_W       = 4,
  parameter int NUM_VREGS  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ID_W-1:0]       in_id,
  input  logic [4:0]            in_vd_addr,
  input  logic [VEC_DATA_W-1:0] in_vd_data,
  output logic                  wr_en,
  input  logic                  wr_ready,
  output logic [4:0]            wr_addr,
  output logic [VEC_DATA_W-1:0] wr_data,
  output logic                  done_valid,
  output logic [ID_W-1:0]       done_id,
  output logic [NUM_VREGS-1:0]  vreg_busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  // FIFO storage, split per field
  logic [ID_W-1:0]       id_q   [DEPTH];
  logic [ID_W-1:0]       id_d   [DEPTH];
  logic [4:0]            addr_q [DEPTH];
  logic [4:0]            addr_d [DEPTH];
  logic [VEC_DATA_W-1:0] data_q [DEPTH];
  logic [VEC_DATA_W-1:0] data_d [DEPTH];

  // FIFO control
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Retire pulse
  logic            done_valid_q, done_valid_d;
  logic [ID_W-1:0] done_id_q, done_id_d;

  // Pending-write counters, one per vector register
  logic [CW-1:0] cnt_q [NUM_VREGS];
  logic [CW-1:0] cnt_d [NUM_VREGS];

  logic enq;
  logic deq;

  // Handshakes come from registered occupancy only, so there is no
  // combinational path from in_valid or wr_ready to any ready/valid output.
  always_comb begin
    in_ready = (count_q < CW'(DEPTH));
    wr_en    = (count_q != '0);
    enq      = in_valid && in_ready;
    deq      = wr_en && wr_ready;
    wr_addr  = addr_q[rd_ptr_q];
    wr_data  = data_q[rd_ptr_q];
  end

  // Next-state for storage, pointers, occupancy and the retire pulse.
  // Flush discards any handshake of its own cycle, so it blocks the storage
  // write as well as the pointer/occupancy updates.
  always_comb begin
    id_d         = id_q;
    addr_d       = addr_q;
    data_d       = data_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    done_valid_d = 1'b0;
    done_id_d    = done_id_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        id_d[wr_ptr_q]   = in_id;
        addr_d[wr_ptr_q] = in_vd_addr;
        data_d[wr_ptr_q] = in_vd_data;
        wr_ptr_d         = wr_ptr_q + AW'(1);
      end
      if (deq) begin
        rd_ptr_d     = rd_ptr_q + AW'(1);
        done_valid_d = 1'b1;
        done_id_d    = id_q[rd_ptr_q];
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Scoreboard: an enqueue and a dequeue hitting the same register in one
  // cycle cancel out because both adjustments are applied to the same value.
  always_comb begin
    vreg_busy = '0;
    for (int r = 0; r < NUM_VREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (enq && (in_vd_addr == 5'(r))) cnt_d[r] = cnt_d[r] + CW'(1);
      if (deq && (wr_addr == 5'(r)))    cnt_d[r] = cnt_d[r] - CW'(1);
      if (flush)                        cnt_d[r] = '0;
      vreg_busy[r] = (cnt_q[r] != '0);
    end
  end

  assign done_valid = done_valid_q;
  assign done_id    = done_id_q;

  // Payload storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    id_q   <= id_d;
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // Control state with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      for (int r = 0; r < NUM_VREGS; r++) cnt_q[r] <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      for (int r = 0; r < NUM_VREGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

endmodule
